// File: rtl/l2_to_l1_msg_queue.sv
// l2_to_l1_msg_queue: in-order LLC-to-L1 message FIFO with duplicate coalescing and illegal-code rejection.
// Optional delivered-message statistics are built when L2L1_MSG_STATS_EN is defined.
module l2_to_l1_msg_queue #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [2:0]                 msg_code,
  input  logic [ADDRESS_SIZE-1:0]    msg_addr,
  output logic                       l1_valid,
  input  logic                       l1_ready,
  output logic [2:0]                 l1_code,
  output logic [ADDRESS_SIZE-1:0]    l1_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       illegal_pulse,
  output logic                       dup_pulse
`ifdef L2L1_MSG_STATS_EN
  ,
  input  logic                       stat_clear,
  output logic [15:0]                stat_getline,
  output logic [15:0]                stat_sendline,
  output logic [15:0]                stat_invalidate,
  output logic [15:0]                stat_evict
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [2:0]              mem_code [DEPTH];
  logic [ADDRESS_SIZE-1:0] mem_addr [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr, tail_ptr;
  logic                    push, pop, legal, tail_live, dup, store;
  assign msg_ready = count != CW'(DEPTH);
  assign l1_valid  = count != '0;
  assign l1_code   = l1_valid ? mem_code[rd_ptr] : 3'd0;
  assign l1_addr   = l1_valid ? mem_addr[rd_ptr] : '0;
  assign push      = msg_valid && msg_ready;
  assign pop       = l1_valid && l1_ready;
  assign legal     = msg_code >= 3'd1 && msg_code <= 3'd4;
  assign tail_ptr  = wr_ptr - PW'(1);
  // The tail is gone this cycle if it is also the head being popped.
  assign tail_live = l1_valid && !(pop && count == CW'(1));
  assign dup       = push && (msg_code == 3'd3 || msg_code == 3'd4) && tail_live &&
                     mem_code[tail_ptr] == msg_code && mem_addr[tail_ptr] == msg_addr;
  assign store     = push && legal && !dup;
  always_ff @(posedge clk) begin
    if (store) begin
      mem_code[wr_ptr] <= msg_code;
      mem_addr[wr_ptr] <= msg_addr;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      illegal_pulse <= 1'b0;
      dup_pulse     <= 1'b0;
    end else begin
      wr_ptr        <= store ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count         <= (store && !pop) ? count + CW'(1) : (!store && pop) ? count - CW'(1) : count;
      illegal_pulse <= push && !legal;
      dup_pulse     <= dup;
    end
  end
`ifdef L2L1_MSG_STATS_EN
  logic [15:0] stat_cnt [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) stat_cnt[i] <= '0;
    end else if (stat_clear) begin
      for (int i = 0; i < 4; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (pop && l1_code == 3'(i + 1) && stat_cnt[i] != 16'hFFFF) stat_cnt[i] <= stat_cnt[i] + 16'd1;
    end
  end
  assign stat_getline    = stat_cnt[0];
  assign stat_sendline   = stat_cnt[1];
  assign stat_invalidate = stat_cnt[2];
  assign stat_evict      = stat_cnt[3];
`endif
endmodule

// File: tb/tb_l2_to_l1_msg_queue.sv
// tb_l2_to_l1_msg_queue: randomized and directed checks of the L2-to-L1 message queue against a queue-based model.
module tb_l2_to_l1_msg_queue;
  localparam int AW = 32;
  localparam int DEPTH = 8;
  typedef struct packed {
    logic [2:0]    code;
    logic [AW-1:0] addr;
  } ent_t;
  logic clk = 0, rst_n = 0;
  logic msg_valid = 0, msg_ready, l1_valid, l1_ready = 0;
  logic [2:0] msg_code = 0, l1_code;
  logic [AW-1:0] msg_addr = 0, l1_addr;
  logic [3:0] count;
  logic illegal_pulse, dup_pulse;
  logic stat_clear = 0;
  logic [15:0] stat_getline, stat_sendline, stat_invalidate, stat_evict;
  int checks = 0, failures = 0;
  ent_t q[$];
  bit exp_ill, exp_dup;
  int exp_stat[4];

  l2_to_l1_msg_queue #(.ADDRESS_SIZE(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_code(msg_code), .msg_addr(msg_addr),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_code(l1_code), .l1_addr(l1_addr),
    .count(count), .illegal_pulse(illegal_pulse), .dup_pulse(dup_pulse)
`ifdef L2L1_MSG_STATS_EN
    , .stat_clear(stat_clear), .stat_getline(stat_getline), .stat_sendline(stat_sendline),
    .stat_invalidate(stat_invalidate), .stat_evict(stat_evict)
`endif
  );

`ifndef L2L1_MSG_STATS_EN
  assign stat_getline = '0;
  assign stat_sendline = '0;
  assign stat_invalidate = '0;
  assign stat_evict = '0;
`endif

  always #5 clk = ~clk;

  // Advance one clock edge, applying the queue rules to the model first.
  task automatic tick();
    int n = q.size();
    bit pop = n > 0 && l1_ready;
    bit took = msg_valid && n < DEPTH;
    bit keep = 0;
    exp_ill = 0;
    exp_dup = 0;
    if (pop && exp_stat[q[0].code - 1] != 16'hFFFF) exp_stat[q[0].code - 1]++;
    if (stat_clear) exp_stat = '{0, 0, 0, 0};
    if (took) begin
      if (msg_code < 1 || msg_code > 4) exp_ill = 1;
      else if ((msg_code == 3 || msg_code == 4) && n > 0 && !(pop && n == 1) &&
               q[n-1].code == msg_code && q[n-1].addr == msg_addr) exp_dup = 1;
      else keep = 1;
    end
    if (pop) void'(q.pop_front());
    if (keep) q.push_back('{code: msg_code, addr: msg_addr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    msg_valid = 0;
    l1_ready = 0;
    stat_clear = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #3;
    q.delete();
    exp_stat = '{0, 0, 0, 0};
    exp_ill = 0;
    exp_dup = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input logic [2:0] c, input logic [AW-1:0] a);
    msg_valid = 1;
    msg_code = c;
    msg_addr = a;
    tick();
    msg_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (msg_ready !== 1 || l1_valid !== 0 || l1_code !== 0 || l1_addr !== 0 || count !== 0 ||
        illegal_pulse !== 0 || dup_pulse !== 0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b code=%0d addr=%h count=%0d ill=%b dup=%b, required 1 0 0 0 0 0 0",
               msg_ready, l1_valid, l1_code, l1_addr, count, illegal_pulse, dup_pulse);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_msg(3'd1, 32'h0000_1000);
    checks++;
    if (l1_valid !== 1 || l1_code !== 3'd1 || l1_addr !== 32'h0000_1000 || count !== 1) begin
      failures++;
      $display("FAIL basic_push: valid=%b code=%0d addr=%h count=%0d, required 1 1 00001000 1",
               l1_valid, l1_code, l1_addr, count);
    end
    l1_ready = 1;
    tick();
    l1_ready = 0;
    checks++;
    if (count !== 0 || l1_code !== 0 || l1_valid !== 0 || l1_addr !== 0) begin
      failures++;
      $display("FAIL basic_pop: count=%0d code=%0d valid=%b addr=%h, required 0 0 0 0", count, l1_code, l1_valid, l1_addr);
    end
  endtask

  task automatic test_full_order();
    do_reset();
    for (int i = 0; i < 8; i++) push_msg(3'((i % 4) + 1), 32'h100 * i + 32'h40);
    checks++;
    if (count !== 8 || msg_ready !== 0) begin
      failures++;
      $display("FAIL full: count=%0d ready=%b, required 8 0", count, msg_ready);
    end
    push_msg(3'd1, 32'hDEAD);
    checks++;
    if (count !== 8 || msg_ready !== 0) begin
      failures++;
      $display("FAIL ninth_offer: count=%0d ready=%b, required 8 0", count, msg_ready);
    end
    l1_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (l1_valid !== 1 || l1_code !== 3'((i % 4) + 1) || l1_addr !== 32'h100 * i + 32'h40) begin
        failures++;
        $display("FAIL drain_order[%0d]: valid=%b code=%0d addr=%h, required 1 %0d %h",
                 i, l1_valid, l1_code, l1_addr, (i % 4) + 1, 32'h100 * i + 32'h40);
      end
      tick();
    end
    l1_ready = 0;
    checks++;
    if (msg_ready !== 1 || l1_valid !== 0 || count !== 0) begin
      failures++;
      $display("FAIL drained: ready=%b valid=%b count=%0d, required 1 0 0", msg_ready, l1_valid, count);
    end
  endtask

  task automatic test_dup();
    int dups = 0;
    do_reset();
    msg_valid = 1;
    msg_code = 3'd3;
    msg_addr = 32'hABC0;
    tick();
    dups += dup_pulse;
    tick();
    msg_valid = 0;
    dups += dup_pulse;
    tick();
    dups += dup_pulse;
    checks++;
    if (count !== 1 || dups != 1) begin
      failures++;
      $display("FAIL dup_invalidate: count=%0d dup_pulses=%0d, required 1 1", count, dups);
    end
    do_reset();
    push_msg(3'd2, 32'hABC0);
    push_msg(3'd2, 32'hABC0);
    checks++;
    if (count !== 2 || dup_pulse !== 0) begin
      failures++;
      $display("FAIL dup_sendline: count=%0d dup=%b, required 2 0", count, dup_pulse);
    end
  endtask

  task automatic test_illegal();
    int ills = 0;
    do_reset();
    push_msg(3'd4, 32'h80);
    push_msg(3'd0, 32'h90);
    ills += illegal_pulse;
    push_msg(3'd7, 32'hA0);
    ills += illegal_pulse;
    tick();
    ills += illegal_pulse;
    checks++;
    if (count !== 1 || ills != 2 || l1_code !== 3'd4) begin
      failures++;
      $display("FAIL illegal: count=%0d illegal_pulses=%0d head=%0d, required 1 2 4", count, ills, l1_code);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 3; i++) push_msg(3'd1, 32'h2000 + i);
    msg_valid = 1;
    l1_ready = 1;
    for (int i = 0; i < 20; i++) begin
      msg_code = 3'd2;
      msg_addr = 32'h3000 + i;
      if (l1_addr !== q[0].addr || l1_code !== q[0].code) bad++;
      tick();
      if (count !== 3) bad++;
    end
    idle();
    checks++;
    if (bad != 0 || count !== 3 || l1_addr !== 32'h3000 + 17) begin
      failures++;
      $display("FAIL back_to_back: errors=%0d count=%0d head=%h, required 0 3 %h", bad, count, l1_addr, 32'h3000 + 17);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    msg_valid = 1;
    for (int i = 0; i < 5; i++) begin
      msg_code = 3'd1;
      msg_addr = 32'h500 + i;
      tick();
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (msg_ready !== 1 || l1_valid !== 0 || l1_code !== 0 || l1_addr !== 0 || count !== 0 ||
        illegal_pulse !== 0 || dup_pulse !== 0) begin
      failures++;
      $display("FAIL async_reset: ready=%b valid=%b code=%0d addr=%h count=%0d, required 1 0 0 0 0",
               msg_ready, l1_valid, l1_code, l1_addr, count);
    end
    idle();
    q.delete();
    exp_stat = '{0, 0, 0, 0};
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      msg_valid = $urandom_range(0, 9) < 7;
      msg_code = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      msg_addr = 32'($urandom_range(0, 2)) << 6;
      l1_ready = $urandom_range(0, 9) < ((i / 100) % 2 ? 3 : 8);
      stat_clear = $urandom_range(0, 63) == 0;
      tick();
      checks++;
      if (count !== 4'(q.size()) || l1_valid !== (q.size() > 0) || msg_ready !== (q.size() < DEPTH) ||
          l1_code !== (q.size() > 0 ? q[0].code : 3'd0) || l1_addr !== (q.size() > 0 ? q[0].addr : 32'd0) ||
          illegal_pulse !== exp_ill || dup_pulse !== exp_dup) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: count=%0d valid=%b code=%0d addr=%h ill=%b dup=%b, required %0d %b %0d %h %b %b",
                   i, count, l1_valid, l1_code, l1_addr, illegal_pulse, dup_pulse, q.size(), q.size() > 0,
                   q.size() > 0 ? q[0].code : 3'd0, q.size() > 0 ? q[0].addr : 32'd0, exp_ill, exp_dup);
      end
`ifdef L2L1_MSG_STATS_EN
      checks++;
      if (stat_getline !== 16'(exp_stat[0]) || stat_sendline !== 16'(exp_stat[1]) ||
          stat_invalidate !== 16'(exp_stat[2]) || stat_evict !== 16'(exp_stat[3])) begin
        failures++;
        $display("FAIL random_stats[%0d]: %0d %0d %0d %0d, required %0d %0d %0d %0d", i, stat_getline,
                 stat_sendline, stat_invalidate, stat_evict, exp_stat[0], exp_stat[1], exp_stat[2], exp_stat[3]);
      end
`endif
    end
    idle();
  endtask

`ifdef L2L1_MSG_STATS_EN
  task automatic test_stats();
    do_reset();
    push_msg(3'd4, 32'h10);
    push_msg(3'd4, 32'h20);
    l1_ready = 1;
    tick();
    tick();
    l1_ready = 0;
    checks++;
    if (stat_evict !== 16'd2 || stat_getline !== 0) begin
      failures++;
      $display("FAIL stat_evict: evict=%0d getline=%0d, required 2 0", stat_evict, stat_getline);
    end
    push_msg(3'd1, 32'h30);
    l1_ready = 1;
    stat_clear = 1;
    tick();
    idle();
    checks++;
    if (stat_getline !== 0 || stat_sendline !== 0 || stat_invalidate !== 0 || stat_evict !== 0 || count !== 0) begin
      failures++;
      $display("FAIL stat_clear: %0d %0d %0d %0d count=%0d, required 0 0 0 0 0",
               stat_getline, stat_sendline, stat_invalidate, stat_evict, count);
    end
  endtask
`endif

  initial begin
    exp_stat = '{0, 0, 0, 0};
    test_reset();
    test_basic();
    test_full_order();
    test_dup();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef L2L1_MSG_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
